// File: rtl/systolic_mac_pe.sv
// Systolic MAC processing element: bit-serial signed multiply of each sample by a
// rotated coefficient, guarded accumulation over a frame, saturated output with handshake.
module systolic_mac_pe #(
   parameter int unsigned WORDLENGTH = 16,
   parameter int unsigned TAPS       = 8,
   parameter int unsigned GUARD      = 4,
   parameter int unsigned EMIT_EVERY = 0
) (
   input  logic                          clk30x,
   input  logic                          reset,
   input  logic                          clear,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic signed [WORDLENGTH-1:0]  inputword,
   input  logic [$clog2(TAPS)-1:0]       start_index,
   input  logic                          coef_we,
   input  logic [$clog2(TAPS)-1:0]       coef_addr,
   input  logic signed [WORDLENGTH-1:0]  coef_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic signed [WORDLENGTH-1:0]  outputword,
   output logic                          out_sat
);

   localparam int unsigned W  = WORDLENGTH;
   localparam int unsigned IW = $clog2(TAPS);
   localparam int unsigned AW = WORDLENGTH + 1 + GUARD;
   localparam int unsigned PW = 2 * WORDLENGTH;
   localparam int unsigned CW = $clog2(WORDLENGTH + 1);

   localparam logic signed [AW-1:0] SAT_MAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      ACC  = 2'd2,
      OUT  = 2'd3
   } state_t;

   state_t state, state_next;

   logic signed [W-1:0]  coef_mem [TAPS];
   logic [IW-1:0]        k;
   logic [IW-1:0]        sidx;
   logic signed [W-1:0]  op_a;
   logic signed [W-1:0]  op_b;
   logic signed [PW-1:0] prod;
   logic signed [AW-1:0] prod_q;
   logic [CW-1:0]        bit_cnt;
   logic signed [AW-1:0] acc;

   logic                 accept_c;
   logic [IW-1:0]        sidx_eff_c;
   logic [IW-1:0]        coef_idx_c;
   logic                 mult_done_c;
   logic                 mbit_c;
   logic signed [PW-1:0] a_ext_c;
   logic signed [PW-1:0] addend_c;
   logic signed [PW-1:0] prod_step_c;
   logic signed [AW-1:0] prod_ext_c;
   logic signed [AW-1:0] acc_base_c;
   logic signed [AW-1:0] acc_new_c;
   logic                 frame_end_c;
   logic                 emit_c;
   logic                 sat_hi_c;
   logic                 sat_lo_c;

   assign in_ready = (state == IDLE) && !clear;
   assign accept_c = in_ready && in_valid;

   // A frame's first sample uses the start_index presented with it.
   assign sidx_eff_c = (k == '0) ? start_index : sidx;
   assign coef_idx_c = k + sidx_eff_c;

   // Shift-add over multiplier bits; the sign bit carries negative weight.
   assign mult_done_c = (bit_cnt == CW'(W));
   assign mbit_c      = |(op_b & (W'(1) << bit_cnt));
   assign a_ext_c     = {{W{op_a[W-1]}}, op_a};
   assign addend_c    = mbit_c ? (a_ext_c <<< bit_cnt) : '0;
   assign prod_step_c = (bit_cnt == CW'(W-1)) ? (prod - addend_c) : (prod + addend_c);
   assign prod_ext_c  = AW'(prod >>> (W-1));

   assign acc_base_c  = (k == '0) ? '0 : acc;
   assign acc_new_c   = acc_base_c + prod_q;
   assign frame_end_c = (k == IW'(TAPS-1));
   assign emit_c      = (EMIT_EVERY != 0) || frame_end_c;
   assign sat_hi_c    = acc_new_c > SAT_MAX;
   assign sat_lo_c    = acc_new_c < SAT_MIN;

   always_ff @(posedge clk30x or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept_c) state_next = MULT;
         MULT:    if (mult_done_c) state_next = ACC;
         ACC:     state_next = emit_c ? OUT : IDLE;
         OUT:     if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (clear) state_next = IDLE;
   end

   // Coefficient bank: writable in any state, independent of clear.
   always_ff @(posedge clk30x or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < TAPS; i++) coef_mem[i] <= '0;
      end else if (coef_we) begin
         coef_mem[coef_addr] <= coef_data;
      end
   end

   // MULT holds W shift-add steps plus one scale step, so out_valid lands W+2 edges after accept.
   always_ff @(posedge clk30x or posedge reset) begin
      if (reset) begin
         k          <= '0;
         sidx       <= '0;
         op_a       <= '0;
         op_b       <= '0;
         prod       <= '0;
         prod_q     <= '0;
         bit_cnt    <= '0;
         acc        <= '0;
         out_valid  <= 1'b0;
         outputword <= '0;
         out_sat    <= 1'b0;
      end else if (clear) begin
         k         <= '0;
         acc       <= '0;
         prod      <= '0;
         bit_cnt   <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept_c) begin
                  op_a    <= inputword;
                  op_b    <= coef_mem[coef_idx_c];
                  prod    <= '0;
                  bit_cnt <= '0;
                  if (k == '0) sidx <= start_index;
               end
            end
            MULT: begin
               if (mult_done_c) begin
                  prod_q <= prod_ext_c;
               end else begin
                  prod    <= prod_step_c;
                  bit_cnt <= bit_cnt + CW'(1);
               end
            end
            ACC: begin
               acc <= acc_new_c;
               k   <= frame_end_c ? '0 : k + IW'(1);
               if (emit_c) begin
                  out_valid  <= 1'b1;
                  out_sat    <= sat_hi_c || sat_lo_c;
                  outputword <= sat_hi_c ? {1'b0, {(W-1){1'b1}}} :
                                sat_lo_c ? {1'b1, {(W-1){1'b0}}} :
                                acc_new_c[W-1:0];
               end
            end
            OUT: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Scoreboard bench for systolic_mac_pe: a frame-level arithmetic model predicts each
// output word; a negedge monitor pops and compares on every output handshake.
module tb_systolic_mac_pe;

   localparam int unsigned W    = 16;
   localparam int unsigned TAPS = 8;
   localparam int unsigned IW   = 3;

   logic                clk30x = 1'b0;
   logic                reset;
   logic                clear;
   logic                in_valid;
   logic                in_ready;
   logic signed [W-1:0] inputword;
   logic [IW-1:0]       start_index;
   logic                coef_we;
   logic [IW-1:0]       coef_addr;
   logic signed [W-1:0] coef_data;
   logic                out_valid;
   logic                out_ready;
   logic [W-1:0]        outputword;
   logic                out_sat;

   typedef struct {
      logic [W-1:0] word;
      logic         sat;
   } exp_t;

   exp_t   exp_q[$];
   exp_t   mon_e;
   int     n_pass  = 0;
   int     n_total = 0;
   int     n_out   = 0;
   int     m_coef [TAPS];
   int     m_k;
   int     m_sidx;
   longint m_acc;

   int     n0;
   int     lat;
   bit     got;
   bit     rnd_we;

   always #5 clk30x = ~clk30x;

   systolic_mac_pe #(
      .WORDLENGTH(W),
      .TAPS(TAPS),
      .GUARD(4),
      .EMIT_EVERY(0)
   ) dut (
      .clk30x(clk30x),
      .reset(reset),
      .clear(clear),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .inputword(inputword),
      .start_index(start_index),
      .coef_we(coef_we),
      .coef_addr(coef_addr),
      .coef_data(coef_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .outputword(outputword),
      .out_sat(out_sat)
   );

   function automatic void check(input string name, input longint act, input longint want);
      n_total++;
      if (act == want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, want);
   endfunction

   function automatic exp_t saturate(input longint v);
      exp_t e;
      if (v > 32767) begin
         e.word = 16'h7FFF;
         e.sat  = 1'b1;
      end else if (v < -32768) begin
         e.word = 16'h8000;
         e.sat  = 1'b1;
      end else begin
         e.word = 16'(v);
         e.sat  = 1'b0;
      end
      return e;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < TAPS; i++) m_coef[i] = 0;
      m_k    = 0;
      m_sidx = 0;
      m_acc  = 0;
   endfunction

   // Q1.15 product floored to Q1.15, summed per frame, saturated at frame end.
   function automatic void model_accept(input int a, input int si);
      longint p;
      int     c;
      if (m_k == 0) m_sidx = si;
      c     = m_coef[(m_k + m_sidx) % TAPS];
      p     = (longint'(a) * longint'(c)) >>> 15;
      m_acc = ((m_k == 0) ? 64'sd0 : m_acc) + p;
      if (m_k == TAPS - 1) exp_q.push_back(saturate(m_acc));
      m_k   = (m_k + 1) % TAPS;
   endfunction

   task automatic step();
      @(posedge clk30x);
      #1;
   endtask

   task automatic write_coef(input logic [IW-1:0] a, input logic signed [W-1:0] d);
      coef_we   = 1'b1;
      coef_addr = a;
      coef_data = d;
      step();
      coef_we   = 1'b0;
      m_coef[a] = int'(d);
   endtask

   task automatic send(input logic signed [W-1:0] a, input logic [IW-1:0] si,
                       input bit we, input logic [IW-1:0] wa, input logic signed [W-1:0] wd);
      int n = 0;
      while (!in_ready && n < 200) begin
         step();
         n++;
      end
      if (!in_ready) begin
         check("send_timeout", 0, 1);
         return;
      end
      inputword   = a;
      start_index = si;
      in_valid    = 1'b1;
      coef_we     = we;
      coef_addr   = wa;
      coef_data   = wd;
      step();
      model_accept(int'(a), int'(si));
      if (we) m_coef[wa] = int'(wd);
      in_valid = 1'b0;
      coef_we  = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         step();
         n++;
      end
      check("drain", exp_q.size(), 0);
      step();
   endtask

   // Monitor: every output handshake must match the oldest prediction.
   always @(negedge clk30x) begin
      if (!reset && out_valid && out_ready) begin
         n_out++;
         if (exp_q.size() == 0) begin
            check("unexpected_out", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("out_word", outputword, mon_e.word);
            check("out_sat", out_sat, mon_e.sat);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b1;
      clear       = 1'b0;
      in_valid    = 1'b0;
      inputword   = '0;
      start_index = '0;
      coef_we     = 1'b0;
      coef_addr   = '0;
      coef_data   = '0;
      out_ready   = 1'b1;
      model_reset();
      repeat (3) step();
      check("rst_out_valid", out_valid, 0);
      check("rst_word", outputword, 0);
      check("rst_sat", out_sat, 0);
      reset = 1'b0;
      step();
      check("rst_in_ready", in_ready, 1);

      // Full-scale frame whose sum reaches +1.0 and must clip.
      n0 = n_out;
      for (int i = 0; i < TAPS; i++) write_coef(IW'(i), 16'sh4000);
      for (int i = 0; i < TAPS; i++) send(16'sh2000, '0, 1'b0, '0, '0);
      drain();
      check("sat_frame_count", n_out - n0, 1);

      // Single live tap selected through two different rotation offsets.
      for (int i = 0; i < TAPS; i++) write_coef(IW'(i), (i == 3) ? 16'sh4000 : 16'sh0000);
      for (int n = 0; n < TAPS; n++) send(W'(256 * (n + 1)), '0, 1'b0, '0, '0);
      drain();
      for (int n = 0; n < TAPS; n++)
         send(W'(256 * (n + 1)), (n == 0) ? IW'(2) : IW'($urandom), 1'b0, '0, '0);
      drain();

      // Random frames with random rotation and occasional writes on the accepting edge.
      n0 = n_out;
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < TAPS; i++) write_coef(IW'(i), W'($urandom));
         for (int n = 0; n < TAPS; n++) begin
            rnd_we = ($urandom_range(0, 3) == 0);
            send(W'($urandom), IW'($urandom), rnd_we, IW'($urandom), W'($urandom));
         end
      end
      drain();
      check("rand_count", n_out - n0, 4);

      // Output backpressure: held result, no acceptance, single transfer on release.
      n0 = n_out;
      out_ready = 1'b0;
      for (int n = 0; n < TAPS; n++) send(W'($urandom), IW'($urandom), 1'b0, '0, '0);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 40) begin
         step();
         lat++;
         if (out_valid) got = 1'b1;
      end
      check("stall_rise", got, 1);
      for (int i = 0; i < 10; i++) begin
         inputword = W'($urandom);
         in_valid  = 1'b1;
         step();
         check("stall_valid", out_valid, 1);
         check("stall_ready", in_ready, 0);
         if (exp_q.size() > 0) check("stall_word", outputword, exp_q[0].word);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      check("stall_release", out_valid, 0);
      drain();
      check("stall_count", n_out - n0, 1);

      // Abort a frame during the multiply of its fourth sample.
      n0 = n_out;
      for (int i = 0; i < 4; i++) send(W'($urandom), IW'($urandom), 1'b0, '0, '0);
      repeat (3) step();
      clear = 1'b1;
      step();
      clear = 1'b0;
      m_k   = 0;
      m_acc = 0;
      repeat (30) step();
      check("clear_no_out", n_out - n0, 0);
      check("clear_ready", in_ready, 1);
      for (int n = 0; n < TAPS; n++) send(W'($urandom), IW'($urandom), 1'b0, '0, '0);
      drain();
      check("clear_next_count", n_out - n0, 1);

      // -1.0 * -1.0 on the first tap clips to +max; measure result latency.
      for (int i = 0; i < TAPS; i++) write_coef(IW'(i), (i == 0) ? 16'sh8000 : 16'sh0000);
      send(16'sh8000, '0, 1'b0, '0, '0);
      for (int n = 1; n < TAPS; n++) send(W'($urandom), IW'($urandom), 1'b0, '0, '0);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 40) begin
         step();
         lat++;
         if (out_valid) got = 1'b1;
      end
      check("latency", lat, W + 2);
      drain();

      // Asynchronous reset between edges while multiplying.
      send(W'($urandom), '0, 1'b0, '0, '0);
      repeat (3) step();
      #2 reset = 1'b1;
      #1;
      check("amid_rst_valid", out_valid, 0);
      check("amid_rst_word", outputword, 0);
      check("amid_rst_sat", out_sat, 0);
      model_reset();
      exp_q.delete();
      step();
      step();
      reset = 1'b0;
      n0 = n_out;
      repeat (30) step();
      check("post_rst_no_out", n_out - n0, 0);
      check("post_rst_ready", in_ready, 1);

      // Coefficient write on the accepting edge must not affect that operand.
      n0 = n_out;
      write_coef('0, 16'sh4000);
      send(16'sh7000, '0, 1'b1, '0, 16'sh7FFF);
      for (int n = 1; n < TAPS; n++) send(W'($urandom), IW'($urandom), 1'b0, '0, '0);
      drain();
      check("rdw_count", n_out - n0, 1);

      check("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
